// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - sequential 8-bit ALU feeding the CPU flag register
// Single-cycle ops finish at the accept edge; shifts and MUL iterate in SHIFT/MUL states.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [7:0]       flags,
  output logic             wrflag,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t     r_state;
  logic [7:0] r_wa;
  logic [7:0] r_wb;
  logic [7:0] r_wh;
  logic [2:0] r_cnt;
  logic [1:0] r_kind;

  logic        w_is_sub;
  logic        w_ci;
  logic [10:0] w_ar;
  logic [7:0]  w_lg;
  logic [7:0]  w_sh_val;
  logic        w_sh_c;
  logic [8:0]  w_mul_sum;
  logic [7:0]  w_mul_hi;
  logic [7:0]  w_mul_lo;

  // Returns {H, V, C, result[7:0]}; subtraction reports borrow in C and H.
  function automatic logic [10:0] f_arith(input logic [7:0] a, input logic [7:0] b,
                                          input logic ci, input logic sub);
    logic [8:0] s;
    logic       h;
    logic       v;
    if (sub) begin
      s = {1'b0, a} - {1'b0, b} - {8'd0, ci};
      h = {1'b0, a[3:0]} < ({1'b0, b[3:0]} + {4'd0, ci});
      v = (a[7] ^ b[7]) & (s[7] ^ a[7]);
    end else begin
      s = {1'b0, a} + {1'b0, b} + {8'd0, ci};
      h = ({1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'd0, ci}) > 5'd15;
      v = ~(a[7] ^ b[7]) & (s[7] ^ a[7]);
    end
    return {h, v, s[8], s[7:0]};
  endfunction

  function automatic logic [7:0] f_flags(input logic [7:0] r, input logic c,
                                         input logic v, input logic h);
    return {2'b00, h, ~^r, v, r[7], ~|r, c};
  endfunction

  always_comb begin
    w_is_sub = op[1] | op[3];
    w_ci     = Cin & op[0] & ~op[3];
    w_ar     = f_arith(A, B, w_ci, w_is_sub);
    w_lg     = 8'd0;
    case (op[1:0])
      2'd0:    w_lg = A & B;
      2'd1:    w_lg = A | B;
      2'd2:    w_lg = A ^ B;
      default: w_lg = ~A;
    endcase
  end

  // One shift step; for ROR the carry equals the bit rotated into bit 7.
  always_comb begin
    w_sh_val = r_wb;
    w_sh_c   = 1'b0;
    case (r_kind)
      2'd0: begin
        w_sh_val = {r_wb[6:0], 1'b0};
        w_sh_c   = r_wb[7];
      end
      2'd1: begin
        w_sh_val = {1'b0, r_wb[7:1]};
        w_sh_c   = r_wb[0];
      end
      default: begin
        w_sh_val = {r_wb[0], r_wb[7:1]};
        w_sh_c   = r_wb[0];
      end
    endcase
  end

  // Shift-add step: multiplier sits in r_wb, product grows into {r_wh, r_wb}.
  always_comb begin
    w_mul_sum = {1'b0, r_wh} + (r_wb[0] ? {1'b0, r_wa} : 9'd0);
    w_mul_hi  = w_mul_sum[8:1];
    w_mul_lo  = {w_mul_sum[0], r_wb[7:1]};
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_wa      <= 8'd0;
      r_wb      <= 8'd0;
      r_wh      <= 8'd0;
      r_cnt     <= 3'd0;
      r_kind    <= 2'd0;
      result    <= '0;
      result_hi <= '0;
      flags     <= 8'd0;
      wrflag    <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      done   <= 1'b0;
      wrflag <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            case (op)
              4'h0, 4'h1, 4'h2, 4'h3: begin
                result    <= w_ar[7:0];
                result_hi <= '0;
                flags     <= f_flags(w_ar[7:0], w_ar[8], w_ar[9], w_ar[10]);
                done      <= 1'b1;
                wrflag    <= 1'b1;
              end
              4'h4, 4'h5, 4'h6, 4'h7: begin
                result    <= w_lg;
                result_hi <= '0;
                flags     <= f_flags(w_lg, 1'b0, 1'b0, 1'b0);
                done      <= 1'b1;
                wrflag    <= 1'b1;
              end
              4'h8, 4'h9, 4'hA: begin
                if (B[2:0] == 3'd0) begin
                  result    <= A;
                  result_hi <= '0;
                  flags     <= f_flags(A, Cin, 1'b0, 1'b0);
                  done      <= 1'b1;
                  wrflag    <= 1'b1;
                end else begin
                  r_wb    <= A;
                  r_kind  <= op[1:0];
                  r_cnt   <= B[2:0];
                  busy    <= 1'b1;
                  r_state <= SHIFT;
                end
              end
              4'hB: begin
                r_wa    <= A;
                r_wb    <= B;
                r_wh    <= 8'd0;
                r_cnt   <= 3'd0;
                busy    <= 1'b1;
                r_state <= MUL;
              end
              4'hC: begin
                flags  <= f_flags(w_ar[7:0], w_ar[8], w_ar[9], w_ar[10]);
                done   <= 1'b1;
                wrflag <= 1'b1;
              end
              4'hD: begin
                result    <= B;
                result_hi <= '0;
                done      <= 1'b1;
              end
              default: done <= 1'b1;
            endcase
          end
        end
        SHIFT: begin
          r_wb  <= w_sh_val;
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd1) begin
            result    <= w_sh_val;
            result_hi <= '0;
            flags     <= f_flags(w_sh_val, w_sh_c, 1'b0, 1'b0);
            done      <= 1'b1;
            wrflag    <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        MUL: begin
          r_wh  <= w_mul_hi;
          r_wb  <= w_mul_lo;
          r_cnt <= r_cnt + 3'd1;
          if (&r_cnt) begin
            result    <= w_mul_lo;
            result_hi <= w_mul_hi;
            flags     <= {2'b00, 1'b0, ~^w_mul_lo, |w_mul_hi, w_mul_hi[7],
                          ~|{w_mul_hi, w_mul_lo}, |w_mul_hi};
            done      <= 1'b1;
            wrflag    <= 1'b1;
            busy      <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - self-checking bench for seq_alu
// Directed cases then random ops against an arithmetic reference model.
module tb_seq_alu;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       start;
  logic [3:0] op;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cin;
  logic [7:0] result;
  logic [7:0] result_hi;
  logic [7:0] flags;
  logic       wrflag;
  logic       done;
  logic       busy;

  seq_alu #(.WIDTH(8)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .op(op), .A(A), .B(B), .Cin(Cin),
    .result(result), .result_hi(result_hi), .flags(flags),
    .wrflag(wrflag), .done(done), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_res;
  logic [7:0] m_hi;
  logic [7:0] m_flags;
  logic       m_wr;
  int         m_lat;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int sgn(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference model: integer arithmetic straight from the opcode definitions.
  task automatic model(input int o, input int a, input int b, input int c);
    int r, s, sr, ci, n, p;
    int cf, vf, hf;
    r = 0; cf = 0; vf = 0; hf = 0;
    m_wr  = 1'b1;
    m_lat = 1;
    case (o)
      0, 1: begin
        ci = (o == 1) ? c : 0;
        s  = a + b + ci;
        r  = s % 256;
        cf = (s > 255);
        hf = ((a % 16) + (b % 16) + ci) > 15;
        sr = sgn(a) + sgn(b) + ci;
        vf = (sr > 127) || (sr < -128);
      end
      2, 3, 12: begin
        ci = (o == 3) ? c : 0;
        s  = a - b - ci;
        r  = (s + 256) % 256;
        cf = (s < 0);
        hf = ((a % 16) - (b % 16) - ci) < 0;
        sr = sgn(a) - sgn(b) - ci;
        vf = (sr > 127) || (sr < -128);
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = 255 - a;
      8, 9, 10: begin
        n = b % 8;
        m_lat = 1 + n;
        if (n == 0) begin
          r = a; cf = c;
        end else if (o == 8) begin
          r = (a << n) % 256; cf = (a >> (8 - n)) % 2;
        end else if (o == 9) begin
          r = a >> n; cf = (a >> (n - 1)) % 2;
        end else begin
          r = ((a >> n) | (a << (8 - n))) % 256; cf = r / 128;
        end
      end
      11: begin
        p = a * b;
        m_lat   = 9;
        m_res   = 8'(p % 256);
        m_hi    = 8'(p / 256);
        m_flags = {2'b00, 1'b0, ($countones(m_res) % 2 == 0), (p > 255),
                   (p >= 32768), (p == 0), (p > 255)};
        return;
      end
      13: begin
        m_res = 8'(b); m_hi = 8'd0; m_wr = 1'b0;
        return;
      end
      default: begin
        m_wr = 1'b0;
        return;
      end
    endcase
    if (o != 12) begin
      m_res = 8'(r);
      m_hi  = 8'd0;
    end
    m_flags = {2'b00, hf[0], ($countones(r[7:0]) % 2 == 0), vf[0], (r >= 128), (r == 0), cf[0]};
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_result"}, result, m_res);
    chk({tag, "_result_hi"}, result_hi, m_hi);
    chk({tag, "_flags"}, flags, m_flags);
  endtask

  // Issue one op, inject an ignored start mid-flight, then check latency and outputs.
  task automatic run_op(input int o, input int a, input int b, input int c);
    int lat;
    @(negedge CLK);
    chk("busy_before_start", busy, 0);
    start = 1'b1; op = 4'(o); A = 8'(a); B = 8'(b); Cin = c[0];
    model(o, a, b, c);
    @(posedge CLK); #1;
    start = 1'b0; A = 8'($urandom); B = 8'($urandom); Cin = 1'($urandom);
    lat = 1;
    while (!done && lat < 20) begin
      chk("busy_in_flight", busy, 1);
      if (lat == 2) begin
        start = 1'b1; op = 4'($urandom);
      end
      @(posedge CLK); #1;
      start = 1'b0;
      lat++;
    end
    chk("latency", lat, m_lat);
    chk("done", done, 1);
    chk("wrflag", wrflag, m_wr);
    chk("busy_at_done", busy, 0);
    check_outs("op");
  endtask

  initial begin
    int cnt;
    Reset = 1'b1; start = 1'b0; op = 4'd0; A = 8'd0; B = 8'd0; Cin = 1'b0;
    m_res = 8'd0; m_hi = 8'd0; m_flags = 8'd0; m_wr = 1'b0; m_lat = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_done", done, 0);
    chk("rst_wrflag", wrflag, 0);
    chk("rst_busy", busy, 0);
    check_outs("rst");
    Reset = 1'b0;

    run_op(0, 8'h7F, 8'h01, 0);
    run_op(2, 8'h10, 8'h20, 0);
    run_op(12, 8'h05, 8'h05, 0);
    run_op(8, 8'h81, 3, 1);
    run_op(8, 8'h81, 0, 1);
    run_op(10, 8'h81, 7, 0);
    run_op(9, 8'h81, 1, 0);
    run_op(11, 8'h10, 8'h10, 0);
    run_op(11, 8'hFF, 8'hFF, 0);
    run_op(11, 8'h00, 8'h37, 1);
    run_op(3, 8'h00, 8'h00, 1);
    run_op(1, 8'hFF, 8'h00, 1);

    // Reset during MUL aborts it with no completion pulse.
    @(negedge CLK);
    start = 1'b1; op = 4'hB; A = 8'h12; B = 8'h34;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    m_res = 8'd0; m_hi = 8'd0; m_flags = 8'd0;
    chk("abort_done", done, 0);
    chk("abort_wrflag", wrflag, 0);
    chk("abort_busy", busy, 0);
    check_outs("abort");
    cnt = 0;
    repeat (10) begin
      @(posedge CLK); #1;
      if (done) cnt++;
    end
    chk("abort_no_done", cnt, 0);

    run_op(0, 8'h01, 8'h01, 0);
    run_op(13, 8'h00, 8'hAA, 0);
    run_op(14, 8'h55, 8'h66, 1);
    run_op(15, 8'h12, 8'h34, 0);

    repeat (300) run_op($urandom_range(15, 0), $urandom_range(255, 0),
                        $urandom_range(255, 0), $urandom_range(1, 0));

    @(posedge CLK); #1;
    chk("done_one_cycle", done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Sequential 8-bit ALU that sits directly upstream of the CPU flag register. It accepts one operation per start pulse and executes it. Single-cycle ops complete in 1 cycle; shifts and multiply iterate over several cycles. On completion it presents the result and an 8-bit flag vector, plus a one-cycle write strobe that the flag register consumes as its flag input and write enable.

## Interface
- WIDTH, 8, operand/result width; flag layout below assumes 8
- CLK  in  1  clock, rising-edge
- Reset  in  1  reset Reset, synchronous, active-high; clock CLK
- start  in  1  request; accepted when start=1 and busy=0
- op  in  4  opcode, sampled at accept
- A  in  WIDTH  operand A, sampled at accept
- B  in  WIDTH  operand B / shift count B[2:0], sampled at accept
- Cin  in  1  carry in (flag register bit 0), sampled at accept
- result  out  WIDTH  result low byte
- result_hi  out  WIDTH  MUL high byte; 0 after any other op
- flags  out  8  {0,0,H,P,V,N,Z,C}: bit0 C, bit1 Z, bit2 N, bit3 V, bit4 P (even parity of result), bit5 H (nibble carry/borrow), bits7:6 always 0
- wrflag  out  1  one-cycle flag-write strobe, coincident with done
- done  out  1  one-cycle completion pulse
- busy  out  1  operation in flight, not yet done

## Operation
- Opcodes:
  - 0 ADD, 1 ADC (A+B+Cin), 2 SUB, 3 SBC (A-B-Cin)
  - 4 AND, 5 OR, 6 XOR, 7 NOT A
  - 8 SHL, 9 SHR (logical), A ROR, each by B[2:0]
  - B MUL (unsigned 8x8→16)
  - C CMP (SUB flags only, result/result_hi unchanged)
  - D PASS B (no flag write)
  - E, F reserved (done only, no state change)
- FSM states: IDLE, SHIFT, MUL.
  - Single-cycle ops: stay in IDLE; outputs register at the accept edge.
  - Shift with n=B[2:0]>0: go to SHIFT, one bit per cycle, return to IDLE after n iterations.
  - MUL: 8 shift-add iterations, then IDLE.
- Arithmetic flags:
  - C = carry out, or borrow for SUB/SBC/CMP.
  - V = signed overflow.
  - H = carry/borrow across bit 3→4.
  - Z, N, P computed from the 8-bit result.
- Logic ops and NOT: C=V=H=0.
- Shifts:
  - C = last bit shifted out; ROR C = final result bit7.
  - n=0 leaves the result equal to A with C=Cin.
  - V=H=0.
- MUL:
  - C=V=(result_hi≠0).
  - Z = (16-bit product==0).
  - N = product bit15.
  - P over the low byte.
  - H=0.
- wrflag=1 with done for every opcode except D, E, F (wrflag=0, flags unchanged).
- result, result_hi, flags hold their values between completions.
- start while busy=1 is ignored; there is no queueing, and operands seen during busy are not captured.

## Timing
- Accept at edge T (start=1, busy=0).
- done/wrflag high during the cycle after:
  - single-cycle ops and shift n=0: T+1
  - shift n>0: T+1+n
  - MUL: T+9
- busy:
  - high from T+1 through the cycle before done
  - never high for single-cycle ops
  - low in the done cycle
- A new start in the done cycle is accepted, so back-to-back ops are allowed. Single-cycle ops sustain one per clock.
- Reset (at any edge, including mid-SHIFT/MUL):
  - state→IDLE, in-flight op aborted
  - result=0, result_hi=0, flags=0x00, done=0, wrflag=0, busy=0
  - no done pulse for the aborted op
- Reset has priority over start in the same cycle.

## Test plan
- ADD A=0x7F, B=0x01 → at T+1: result=0x80, flags=0x2C (N,V,H), done=wrflag=1, busy never high.
- SUB A=0x10, B=0x20 → result=0xF0, flags=0x15 (C,N,P). Then CMP A=0x05, B=0x05 → flags=0x12 (Z,P), result still 0xF0, wrflag=1.
- SHL A=0x81, B=3 → busy at T+1..T+3; at T+4: result=0x08, flags=0x00, done=1. Repeat with B=0 → at T+1: result=0x81, C=Cin.
- MUL A=0x10, B=0x10 → done at T+9, result_hi=0x01, result=0x00, flags=0x19. A start at T+3 is ignored (no extra done).
- Reset asserted at T+4 of a MUL → all outputs 0 next cycle, no done. Then ADD 0x01+0x01 is accepted: result=0x02, flags=0x00 at +1.
- PASS B B=0xAA after ADD → result=0xAA, done=1, wrflag=0, flags keep the ADD value. Opcode E → done=1, wrflag=0, result unchanged.
